// File: rtl/ldpc_3gpp_enc_p2_buf_pkg.sv
// Shared encoder types: data word, lifting size, row vector and the p2 buffer FSM states.
package ldpc_3gpp_enc_p2_buf_pkg;

  localparam int unsigned cDAT_W = 8;
  localparam int unsigned cZC_W  = 9;
  localparam int unsigned cNROW  = 3;

  typedef logic [cDAT_W-1:0] dat_t;
  typedef logic [cZC_W-1:0]  hb_zc_t;
  typedef dat_t [cNROW-1:0]  row_vec_t;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDrain
  } p2_state_t;

endpackage

// File: rtl/ldpc_3gpp_enc_p2_xor_tri.sv
// p2 XOR network: prefix XOR over rows (lower-triangular T) or per-row XOR (identity T),
// with an optional register stage that carries the word's control alongside the data.
module ldpc_3gpp_enc_p2_xor_tri
  import ldpc_3gpp_enc_p2_buf_pkg::*;
#(
  parameter int pDAT_W  = 8,
  parameter int pADDR_W = 8,
  parameter int pNROW   = 3,
  parameter int pPIPE   = 0
) (
  input  logic                    iclk,
  input  logic                    ireset,
  input  logic                    iclkena,
  input  logic                    ival,
  input  logic                    isop,
  input  logic                    ilast,
  input  logic                    imode,
  input  logic [pADDR_W-1:0]      iaddr,
  input  logic [pNROW*pDAT_W-1:0] iau,
  input  logic [pNROW*pDAT_W-1:0] ibp1,
  output logic                    oval,
  output logic                    osop,
  output logic                    olast,
  output logic [pADDR_W-1:0]      oaddr,
  output logic [pNROW*pDAT_W-1:0] odat
);

  logic [pNROW*pDAT_W-1:0] p2;
  logic [pDAT_W-1:0]       acc;
  logic [pDAT_W-1:0]       s;

  // Row r gets s[r] in identity mode, s[0]^..^s[r] in triangular mode.
  always_comb begin
    p2  = '0;
    acc = '0;
    s   = '0;
    for (int r = 0; r < pNROW; r++) begin
      s   = iau[r*pDAT_W +: pDAT_W] ^ ibp1[r*pDAT_W +: pDAT_W];
      acc = acc ^ s;
      p2[r*pDAT_W +: pDAT_W] = imode ? s : acc;
    end
  end

  if (pPIPE != 0) begin : g_pipe
    // Optional pipeline register on the XOR result and its control.
    always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
        oval  <= 1'b0;
        osop  <= 1'b0;
        olast <= 1'b0;
        oaddr <= '0;
        odat  <= '0;
      end else if (iclkena) begin
        oval  <= ival;
        osop  <= isop;
        olast <= ilast;
        oaddr <= iaddr;
        odat  <= p2;
      end
    end
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk = ^{iclk, ireset, iclkena};
    assign oval  = ival;
    assign osop  = isop;
    assign olast = ilast;
    assign oaddr = iaddr;
    assign odat  = p2;
  end

endmodule

// File: rtl/ldpc_3gpp_enc_p2_buf.sv
// p2 parity engine: per-word T^-1 XOR, whole-block buffer, row-major drain and p3 tap.
module ldpc_3gpp_enc_p2_buf
  import ldpc_3gpp_enc_p2_buf_pkg::*;
#(
  parameter int pDAT_W  = 8,
  parameter int pADDR_W = 8,
  parameter int pNROW   = 3,
  parameter int pPIPE   = 0
) (
  input  logic                       iclk,
  input  logic                       ireset,
  input  logic                       iclkena,
  input  logic                       imode,
  input  logic [pADDR_W-1:0]         iused_words,
  input  logic                       ival,
  input  logic                       isop,
  input  logic                       ieop,
  output logic                       oirdy,
  input  logic [pNROW*pDAT_W-1:0]    iau,
  input  logic [pNROW*pDAT_W-1:0]    ibp1,
  output logic                       oval,
  output logic                       osop,
  output logic                       oeop,
  input  logic                       iordy,
  output logic [$clog2(pNROW)-1:0]   orow,
  output logic [pADDR_W-1:0]         oaddr,
  output logic [pDAT_W-1:0]          odat,
  output logic                       owrite2p3,
  output logic                       owstart2p3,
  output logic [pNROW*pDAT_W-1:0]    owdat2p3,
  output logic                       oerr
);

  localparam int ROW_W = $clog2(pNROW);
  localparam int DEPTH = 2 ** pADDR_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(pNROW - 1);

  p2_state_t           state;
  logic [pADDR_W-1:0]  cnt;
  logic [pADDR_W-1:0]  used;
  logic                mode;
  logic                eop_seen;

  logic                accept;
  logic                start;
  logic                take;
  logic [pADDR_W-1:0]  word;
  logic [pADDR_W-1:0]  used_eff;
  logic                mode_eff;
  logic                early;
  logic                last_word;

  logic                    x_val;
  logic                    x_sop;
  logic                    x_last;
  logic [pADDR_W-1:0]      x_addr;
  logic [pNROW*pDAT_W-1:0] x_p2;

  logic [pDAT_W-1:0]   mem [pNROW][DEPTH];

  logic                rd_go;
  logic                rd_first;
  logic                rd_more;
  logic                rd_en;
  logic                more_left;
  logic [ROW_W-1:0]    rrow;
  logic [pADDR_W-1:0]  raddr;
  logic [pDAT_W-1:0]   rd_word;

  assign oirdy  = (state != StDrain);
  assign accept = iclkena & ival & oirdy;
  assign start  = accept & isop;
  assign take   = start | (accept & (state == StFill));

  // isop beats use the live parameters; later words use the ones latched at isop.
  assign word      = isop ? '0 : cnt;
  assign used_eff  = isop ? iused_words : used;
  assign mode_eff  = isop ? imode : mode;
  assign early     = isop ? 1'b0 : eop_seen;
  assign last_word = (word == used_eff);

  ldpc_3gpp_enc_p2_xor_tri #(
    .pDAT_W  (pDAT_W),
    .pADDR_W (pADDR_W),
    .pNROW   (pNROW),
    .pPIPE   (pPIPE)
  ) u_xor (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .ival    (take),
    .isop    (word == '0),
    .ilast   (last_word),
    .imode   (mode_eff),
    .iaddr   (word),
    .iau     (iau),
    .ibp1    (ibp1),
    .oval    (x_val),
    .osop    (x_sop),
    .olast   (x_last),
    .oaddr   (x_addr),
    .odat    (x_p2)
  );

  // Input FSM: block framing, parameter latching and ieop consistency check.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state    <= StIdle;
      cnt      <= '0;
      used     <= '0;
      mode     <= 1'b0;
      eop_seen <= 1'b0;
      oerr     <= 1'b0;
    end else if (iclkena) begin
      if (take) begin
        mode <= mode_eff;
        used <= used_eff;
        if (start) oerr <= 1'b0;
        if (last_word) begin
          state    <= StDrain;
          oerr     <= ~ieop | early;
          eop_seen <= 1'b0;
        end else begin
          state    <= StFill;
          cnt      <= word + 1'b1;
          eop_seen <= early | ieop;
        end
      end else if (state == StDrain && oval && iordy && oeop) begin
        state <= StIdle;
      end
    end
  end

  // p3 tap register; the buffer is written on the same edge.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      owrite2p3  <= 1'b0;
      owstart2p3 <= 1'b0;
      owdat2p3   <= '0;
    end else if (iclkena) begin
      owrite2p3  <= x_val;
      owstart2p3 <= x_val & x_sop;
      if (x_val) owdat2p3 <= x_p2;
    end
  end

  // Result buffer write: all rows of one word at once.
  always_ff @(posedge iclk) begin
    if (iclkena && x_val) begin
      for (int r = 0; r < pNROW; r++) begin
        mem[r][x_addr] <= x_p2[r*pDAT_W +: pDAT_W];
      end
    end
  end

  // The first read fires on the edge that writes the last word; later reads advance the
  // output register whenever it is empty or being consumed, so stalls hold it in place.
  assign rd_first  = x_val & x_last;
  assign more_left = !((orow == LAST_ROW) && (oaddr == used));
  assign rd_more   = rd_go & more_left & (~oval | iordy);
  assign rd_en     = rd_first | rd_more;

  // Next read address in row-major order.
  always_comb begin
    rrow  = orow;
    raddr = oaddr + 1'b1;
    if (rd_first) begin
      rrow  = '0;
      raddr = '0;
    end else if (oaddr == used) begin
      rrow  = orow + 1'b1;
      raddr = '0;
    end
  end

  // Buffer read with forwarding of a word written on the same edge.
  always_comb begin
    rd_word = mem[rrow][raddr];
    if (x_val && (x_addr == raddr)) rd_word = x_p2[rrow*pDAT_W +: pDAT_W];
  end

  // Output register doubling as the registered buffer read.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      rd_go <= 1'b0;
      oval  <= 1'b0;
      osop  <= 1'b0;
      oeop  <= 1'b0;
      orow  <= '0;
      oaddr <= '0;
      odat  <= '0;
    end else if (iclkena) begin
      if (rd_first) begin
        rd_go <= 1'b1;
      end else if (oval && iordy && oeop) begin
        rd_go <= 1'b0;
      end
      if (rd_en) begin
        oval  <= 1'b1;
        osop  <= rd_first;
        oeop  <= (rrow == LAST_ROW) && (raddr == used);
        orow  <= rrow;
        oaddr <= raddr;
        odat  <= rd_word;
      end else if (iordy) begin
        oval <= 1'b0;
        osop <= 1'b0;
        oeop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ldpc_3gpp_enc_p2_buf.sv
// Self-checking bench for ldpc_3gpp_enc_p2_buf (pNROW = 3, pDAT_W = 8, pPIPE = 0).
module tb_ldpc_3gpp_enc_p2_buf;

  localparam int DW   = 8;
  localparam int AW   = 8;
  localparam int NR   = 3;
  localparam int PIPE = 0;

  logic           iclk = 1'b0;
  logic           ireset;
  logic           iclkena;
  logic           imode;
  logic [AW-1:0]  iused_words;
  logic           ival;
  logic           isop;
  logic           ieop;
  logic           oirdy;
  logic [NR*DW-1:0] iau;
  logic [NR*DW-1:0] ibp1;
  logic           oval;
  logic           osop;
  logic           oeop;
  logic           iordy;
  logic [1:0]     orow;
  logic [AW-1:0]  oaddr;
  logic [DW-1:0]  odat;
  logic           owrite2p3;
  logic           owstart2p3;
  logic [NR*DW-1:0] owdat2p3;
  logic           oerr;

  ldpc_3gpp_enc_p2_buf #(
    .pDAT_W  (DW),
    .pADDR_W (AW),
    .pNROW   (NR),
    .pPIPE   (PIPE)
  ) dut (
    .iclk        (iclk),
    .ireset      (ireset),
    .iclkena     (iclkena),
    .imode       (imode),
    .iused_words (iused_words),
    .ival        (ival),
    .isop        (isop),
    .ieop        (ieop),
    .oirdy       (oirdy),
    .iau         (iau),
    .ibp1        (ibp1),
    .oval        (oval),
    .osop        (osop),
    .oeop        (oeop),
    .iordy       (iordy),
    .orow        (orow),
    .oaddr       (oaddr),
    .odat        (odat),
    .owrite2p3   (owrite2p3),
    .owstart2p3  (owstart2p3),
    .owdat2p3    (owdat2p3),
    .oerr        (oerr)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int         row;
    int         addr;
    logic [7:0] dat;
    logic       sop;
    logic       eop;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] got_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model of the block framing and p2 computation.
  logic       m_active = 1'b0;
  logic       m_mode;
  logic       m_early;
  logic       m_err;
  int         m_used;
  int         m_cnt;
  logic [7:0] m_buf [NR][256];

  // Drive one word (assumed accepted when oirdy is 1) and advance the model.
  task automatic send_word(input logic sop, input logic eop, input logic mode,
                           input int used, input logic [23:0] s);
    logic [7:0]  acc;
    logic [7:0]  p2 [NR];
    logic [23:0] au;
    au          = 24'($urandom);
    imode       = mode;
    iused_words = AW'(used);
    isop        = sop;
    ieop        = eop;
    iau         = au;
    ibp1        = au ^ s;
    ival        = 1'b1;
    @(posedge iclk);
    #1;
    ival = 1'b0;
    isop = 1'b0;
    ieop = 1'b0;
    if (sop) begin
      m_active = 1'b1;
      m_mode   = mode;
      m_used   = used;
      m_cnt    = 0;
      m_early  = 1'b0;
    end
    if (m_active) begin
      acc = 8'h00;
      for (int r = 0; r < NR; r++) begin
        acc   = acc ^ s[r*8 +: 8];
        p2[r] = m_mode ? s[r*8 +: 8] : acc;
        m_buf[r][m_cnt] = p2[r];
      end
      if (m_cnt == m_used) begin
        m_err    = !eop || m_early;
        m_active = 1'b0;
        for (int r = 0; r < NR; r++) begin
          for (int a = 0; a <= m_used; a++) begin
            exp_q.push_back('{r, a, m_buf[r][a], (r == 0 && a == 0),
                              (r == NR - 1 && a == m_used)});
          end
        end
      end else begin
        m_early = m_early | eop;
        m_cnt++;
      end
    end
  endtask

  // Consume output beats against the scoreboard; pat 0 = always ready, 1 = ready 1,0,0,...
  task automatic drain(input int pat);
    int         cyc     = 0;
    logic       stalled = 1'b0;
    logic [1:0] prow    = '0;
    logic [7:0] paddr   = '0;
    logic [7:0] pdat    = '0;
    beat_t      e;
    got_q.delete();
    while (exp_q.size() > 0 && cyc < 400) begin
      iordy = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
      @(negedge iclk);
      if (stalled) begin
        n_cmp++;
        if (oval !== 1'b1 || orow !== prow || oaddr !== paddr || odat !== pdat) begin
          n_bad++;
          $display("FAIL hold: got val=%b row=%0d addr=%0d dat=%h, need val=1 row=%0d addr=%0d dat=%h",
                   oval, orow, oaddr, odat, prow, paddr, pdat);
        end
      end
      if (oval === 1'b1 && iordy) begin
        e = exp_q.pop_front();
        got_q.push_back(odat);
        n_cmp++;
        if (orow !== 2'(e.row) || oaddr !== 8'(e.addr) || odat !== e.dat ||
            osop !== e.sop || oeop !== e.eop) begin
          n_bad++;
          $display("FAIL beat: got row=%0d addr=%0d dat=%h sop=%b eop=%b, need row=%0d addr=%0d dat=%h sop=%b eop=%b",
                   orow, oaddr, odat, osop, oeop, e.row, e.addr, e.dat, e.sop, e.eop);
        end
        n_cmp++;
        if (oirdy !== 1'b0) begin
          n_bad++;
          $display("FAIL drain_irdy: got oirdy=%b, need 0", oirdy);
        end
      end
      stalled = (oval === 1'b1) && !iordy;
      prow    = orow;
      paddr   = oaddr;
      pdat    = odat;
      @(posedge iclk);
      #1;
      cyc++;
    end
    iordy = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats left, need 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (oirdy !== 1'b1) begin
      n_bad++;
      $display("FAIL turnaround: got oirdy=%b, need 1", oirdy);
    end
    @(negedge iclk);
    n_cmp++;
    if (oval !== 1'b0) begin
      n_bad++;
      $display("FAIL extra_beat: got oval=%b, need 0", oval);
    end
    @(posedge iclk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge iclk);
    @(posedge iclk);
    #1;
    n_cmp++;
    if (oirdy !== 1'b1) begin n_bad++; $display("FAIL reset_irdy: got %b, need 1", oirdy); end
    n_cmp++;
    if ({oval, osop, oeop, owrite2p3, owstart2p3, oerr} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, need 000000",
               {oval, osop, oeop, owrite2p3, owstart2p3, oerr});
    end
    n_cmp++;
    if ({orow, oaddr, odat, owdat2p3} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got row=%0d addr=%0d dat=%h tap=%h, need all 0",
               orow, oaddr, odat, owdat2p3);
    end
    ireset = 1'b0;
    @(posedge iclk);
    #1;
  endtask

  task automatic test_mode0();
    logic [7:0] lit [6] = '{8'h01, 8'hFF, 8'h03, 8'hF0, 8'h07, 8'h00};
    // A word without isop in IDLE is dropped.
    send_word(1'b0, 1'b1, 1'b0, 1, 24'h112233);
    @(posedge iclk);
    #1;
    n_cmp++;
    if (oirdy !== 1'b1 || oval !== 1'b0) begin
      n_bad++;
      $display("FAIL drop: got oirdy=%b oval=%b, need 1 0", oirdy, oval);
    end
    send_word(1'b1, 1'b0, 1'b0, 1, 24'h040201);
    send_word(1'b0, 1'b1, 1'b0, 1, 24'hF00FFF);
    drain(0);
    n_cmp++;
    if (got_q.size() != 6) begin
      n_bad++;
      $display("FAIL mode0_count: got %0d beats, need 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (got_q[i] !== lit[i]) begin
          n_bad++;
          $display("FAIL mode0_dat[%0d]: got %h, need %h", i, got_q[i], lit[i]);
        end
      end
    end
  endtask

  task automatic test_mode1();
    logic [7:0] lit [6] = '{8'h01, 8'hFF, 8'h02, 8'h0F, 8'h04, 8'hF0};
    send_word(1'b1, 1'b0, 1'b1, 1, 24'h040201);
    n_cmp++;
    if (owrite2p3 !== 1'b1 || owstart2p3 !== 1'b1 || owdat2p3 !== 24'h040201) begin
      n_bad++;
      $display("FAIL tap_w0: got wr=%b st=%b dat=%h, need 1 1 040201",
               owrite2p3, owstart2p3, owdat2p3);
    end
    send_word(1'b0, 1'b1, 1'b1, 1, 24'hF00FFF);
    n_cmp++;
    if (owrite2p3 !== 1'b1 || owstart2p3 !== 1'b0 || owdat2p3 !== 24'hF00FFF) begin
      n_bad++;
      $display("FAIL tap_w1: got wr=%b st=%b dat=%h, need 1 0 f00fff",
               owrite2p3, owstart2p3, owdat2p3);
    end
    @(posedge iclk);
    #1;
    n_cmp++;
    if (owrite2p3 !== 1'b0) begin
      n_bad++;
      $display("FAIL tap_pulse: got wr=%b, need 0", owrite2p3);
    end
    drain(0);
    n_cmp++;
    if (got_q.size() != 6) begin
      n_bad++;
      $display("FAIL mode1_count: got %0d beats, need 6", got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (got_q[i] !== lit[i]) begin
          n_bad++;
          $display("FAIL mode1_dat[%0d]: got %h, need %h", i, got_q[i], lit[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int w = 0; w < 4; w++) begin
      send_word(w == 0, w == 3, 1'b0, 3, 24'($urandom));
    end
    drain(1);
  endtask

  task automatic test_eop();
    send_word(1'b1, 1'b1, 1'b0, 2, 24'hA5C3E1);
    send_word(1'b0, 1'b0, 1'b0, 2, 24'h5A3C1E);
    send_word(1'b0, 1'b0, 1'b0, 2, 24'h123456);
    drain(0);
    n_cmp++;
    if (oerr !== 1'b1) begin
      n_bad++;
      $display("FAIL eop_err_set: got oerr=%b, need 1", oerr);
    end
    // Single-word block with correct ieop clears the flag.
    send_word(1'b1, 1'b1, 1'b1, 0, 24'h00BEEF);
    n_cmp++;
    if (oerr !== 1'b0) begin
      n_bad++;
      $display("FAIL eop_err_clr: got oerr=%b, need 0", oerr);
    end
    drain(0);
  endtask

  task automatic test_restart();
    send_word(1'b1, 1'b0, 1'b0, 2, 24'hDEAD01);
    send_word(1'b1, 1'b0, 1'b0, 1, 24'h0C0B0A);
    send_word(1'b0, 1'b1, 1'b0, 1, 24'h30C060);
    drain(0);
    n_cmp++;
    if (oerr !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_err: got oerr=%b, need 0", oerr);
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int w = 0; w < 3; w++) begin
      send_word(w == 0, w == 2, 1'b1, 2, 24'($urandom));
    end
    iordy = 1'b1;
    @(posedge iclk);
    #1;
    @(posedge iclk);
    #1;
    iordy = 1'b0;
    @(negedge iclk);
    ireset = 1'b1;
    #1;
    n_cmp++;
    if (oval !== 1'b0 || oirdy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset: got oval=%b oirdy=%b, need 0 1", oval, oirdy);
    end
    exp_q.delete();
    m_active = 1'b0;
    @(posedge iclk);
    #1;
    ireset = 1'b0;
    @(posedge iclk);
    #1;
    for (int w = 0; w < 5; w++) begin
      send_word(w == 0, w == 4, 1'b0, 4, 24'($urandom));
    end
    drain(0);
  endtask

  initial begin
    ireset      = 1'b1;
    iclkena     = 1'b1;
    imode       = 1'b0;
    iused_words = '0;
    ival        = 1'b0;
    isop        = 1'b0;
    ieop        = 1'b0;
    iau         = '0;
    ibp1        = '0;
    iordy       = 1'b0;
    test_reset();
    test_mode0();
    test_mode1();
    test_backpressure();
    test_eop();
    test_restart();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, need finish before time limit");
    $fatal(1);
  end

endmodule
